// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the modular-arithmetic blocks.
package ntt_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_Q     = 3329;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_mult.sv
// Combinational modular multiplier: p_o = (a_i * b_i) mod Q.
// The product is kept at full double width so nothing is lost before the reduction.
module mod_mult #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned Q     = 3329
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  localparam logic [2*WIDTH-1:0] Q_2W = (2*WIDTH)'(Q);

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    p_o  = WIDTH'(prod % Q_2W);
  end

endmodule

// File: rtl/mod_inv.sv
// Modular inverse a^(Q-2) mod Q (Fermat) using right-to-left square-and-multiply,
// one exponent bit per cycle.
//
//   state   | meaning
//   IDLE    | waiting for start; result/err hold the last answer
//   RUN     | EBITS square-and-multiply steps
//   DONE    | one-cycle done pulse, then back to IDLE
module mod_inv
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned Q     = DEFAULT_Q
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  // EBITS is the bit length of Q-2; clog2(n+1) gives the bit length of n.
  localparam int unsigned EBITS = $clog2(Q - 1);
  localparam int unsigned CNT_W = $clog2(EBITS + 1);

  localparam logic [WIDTH-1:0] Q_W      = WIDTH'(Q);
  localparam logic [EBITS-1:0] EXP_INIT = EBITS'(Q - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EBITS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [EBITS-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   a_red;
  logic [WIDTH-1:0]   acc_mul;
  logic [WIDTH-1:0]   base_sq;
  logic [WIDTH-1:0]   acc_nxt;

  assign a_red = a % Q_W;

  mod_mult #(.WIDTH(WIDTH), .Q(Q)) u_mul_acc (
    .a_i (acc_q),
    .b_i (base_q),
    .p_o (acc_mul)
  );

  mod_mult #(.WIDTH(WIDTH), .Q(Q)) u_mul_sq (
    .a_i (base_q),
    .b_i (base_q),
    .p_o (base_sq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    acc_nxt  = exp_q[0] ? acc_mul : acc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = a_red;
          acc_d   = WIDTH'(1);
          exp_d   = EXP_INIT;
          cnt_d   = '0;
          err_d   = (a_red == '0);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d  = acc_nxt;
        base_d = base_sq;
        exp_d  = exp_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        // The last step's product goes straight to result, so DONE sees it already.
        if (cnt_q == CNT_LAST) begin
          result_d = acc_nxt;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_inv.sv
// Scoreboard bench for mod_inv: stimulus pushes expected answers, a monitor pops on done.
module tb_mod_inv;

  localparam int unsigned W = 32;
  localparam longint QM = 3329;
  localparam longint LAT = 13;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] res;
    logic         err;
    longint       cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  exp_t   sb[$];

  logic         prev_done = 1'b0;
  logic         hold_valid = 1'b0;
  logic [W-1:0] hold_res;
  logic         hold_err;

  mod_inv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inverse via extended Euclid; 0 when a is a multiple of Q.
  function automatic logic [W-1:0] ref_inv(input logic [W-1:0] av);
    longint r0, r1, t0, t1, qq, tmp;
    r0 = QM;
    r1 = longint'(av) % QM;
    if (r1 == 0) return '0;
    t0 = 0;
    t1 = 1;
    while (r1 != 0) begin
      qq  = r0 / r1;
      tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
      tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
    end
    if (t0 < 0) t0 = t0 + QM;
    return W'(t0);
  endfunction

  function automatic void push_exp(input logic [W-1:0] av, input longint accept_cyc);
    exp_t e;
    e.a   = av;
    e.res = ref_inv(av);
    e.err = ((longint'(av) % QM) == 0);
    e.cyc = accept_cyc + LAT;
    sb.push_back(e);
  endfunction

  // Call at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [W-1:0] av);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout busy=%0b required=0", busy);
    end
    start = 1'b1;
    a     = av;
    push_exp(av, cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy || sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout busy=%0b pending=%0d required=0", busy, sb.size());
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s busy=%0b done=%0b result=%0d err=%0b required all 0",
               tag, busy, done, result, err);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (done) begin
        checks++;
        if (prev_done) begin
          failures++;
          $display("FAIL done_width done high on consecutive cycles at cyc=%0d", cyc);
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done at cyc=%0d result=%0d", cyc, result);
        end else begin
          e = sb.pop_front();
          if (result !== e.res) begin
            failures++;
            $display("FAIL result a=%0d got=%0d required=%0d", e.a, result, e.res);
          end
          checks++;
          if (err !== e.err) begin
            failures++;
            $display("FAIL err a=%0d got=%0b required=%0b", e.a, err, e.err);
          end
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL latency a=%0d done_cyc=%0d required=%0d", e.a, cyc, e.cyc);
          end
          if (!e.err) begin
            checks++;
            if (((longint'(e.a) % QM) * longint'(result)) % QM != 1) begin
              failures++;
              $display("FAIL inverse_product a=%0d result=%0d product_mod=%0d required=1",
                       e.a, result, ((longint'(e.a) % QM) * longint'(result)) % QM);
            end
          end
          hold_res   = e.res;
          hold_err   = e.err;
          hold_valid = 1'b1;
        end
      end else if (!busy && hold_valid) begin
        checks++;
        if (result !== hold_res || err !== hold_err) begin
          failures++;
          $display("FAIL hold result=%0d err=%0b required result=%0d err=%0b",
                   result, err, hold_res, hold_err);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    logic [W-1:0] directed[8];
    int unsigned  sweep[3328];
    int unsigned  j, tmp;
    directed = '{32'd2, 32'd17, 32'd3328, 32'd1, 32'd0, 32'd3331, 32'd3329, 32'd6658};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");

    // First start on the first edge after reset deasserts.
    rst = 1'b0;
    foreach (directed[i]) issue(directed[i]);
    wait_idle();

    // Back-to-back: start held high, random operands while RUN/DONE must be ignored.
    start = 1'b1;
    a     = 32'd2;
    push_exp(32'd2, cyc);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      a = $urandom;
    end
    @(negedge clk);
    a = 32'd17;
    push_exp(32'd17, cyc);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    wait_idle();

    // Reset in RUN aborts; reset dominates a simultaneous start.
    start = 1'b1;
    a     = 32'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'd5;
    @(negedge clk);
    check_zero("reset_abort");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_zero("post_reset_idle");
    issue(32'd17);
    wait_idle();

    for (int k = 0; k < 40; k++) issue($urandom);
    wait_idle();

    for (int unsigned i = 0; i < 3328; i++) sweep[i] = i + 1;
    for (int i = 3327; i > 0; i--) begin
      j        = $urandom_range(i, 0);
      tmp      = sweep[i];
      sweep[i] = sweep[j];
      sweep[j] = tmp;
    end
    foreach (sweep[i]) issue(W'(sweep[i]));
    wait_idle();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_inv.md
MOD_INV -- requirements
Module: mod_inv

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result bit width.
REQ-002 SHALL have parameter Q, default 3329: prime modulus, 3 <= Q < 2**WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  operand, any value, sampled on the accepting edge.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL have port result  output  WIDTH  a^-1 mod Q, in [0, Q-1].
REQ-010 SHALL have port err  output  1  set with done when (a mod Q) == 0.

Function
REQ-011 SHALL compute a^(Q-2) mod Q (Fermat) by right-to-left square-and-multiply.
REQ-012 SHALL define EBITS = bit length of Q-2 (12 for Q=3329).
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE & start: base <= a mod Q, acc <= 1, exp <= Q-2, cnt <= 0, err register <= (a mod Q == 0), next RUN.
REQ-015 IDLE & !start: remain IDLE, result and err hold.
REQ-016 RUN, each cycle: if exp[0] then acc <= (acc*base) mod Q; base <= (base*base) mod Q; exp <= exp>>1; cnt <= cnt+1.
REQ-017 RUN: after exactly EBITS cycles, result <= final acc, next DONE.
REQ-018 DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
REQ-019 Latency: start accepted in cycle 0 -> done high in cycle EBITS+1 (13 for Q=3329); next start accepted in cycle EBITS+2 at earliest.
REQ-020 start in RUN or DONE SHALL be ignored, with no effect on the computation in flight.
REQ-021 Products SHALL be formed at 2*WIDTH bits before reduction; no truncation before the mod.
REQ-022 result and err SHALL stay stable from done until the next accepted start.
REQ-023 a == 0 mod Q: result = 0, err = 1, latency unchanged.
REQ-024 a >= Q: SHALL first be reduced mod Q; a == Q gives err = 1.

Reset
REQ-025 rst SHALL force IDLE, busy=0, done=0, result=0, err=0, acc/base/exp/cnt=0.
REQ-026 rst mid-RUN or in DONE SHALL abort with no done pulse; rst dominates a simultaneous start.
REQ-027 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-028 Package ntt_pkg SHALL hold the default Q and WIDTH constants and the FSM state enum typedef.
REQ-029 The block SHALL instantiate two mod_mult sub-modules, one for acc*base and one for base*base, both parameterized with WIDTH and Q.
REQ-030 EBITS and the cnt width SHALL be derived from Q at elaboration.
REQ-031 The only registered state SHALL be acc, base, exp, cnt, state, result and err.

Verification
REQ-032 a=2 -> done in cycle 13, result=1665, err=0.
REQ-033 a=17 -> result=1175; a=3328 -> result=3328; a=1 -> result=1.
REQ-034 a=0 -> result=0, err=1; a=3331 -> result=1665, err=0.
REQ-035 Back-to-back: a=2, then start held high throughout -> second request accepted in cycle 14; start pulses in cycles 1..13 ignored.
REQ-036 rst in cycle 5 of RUN -> no done pulse, all outputs 0 next cycle; a fresh a=17 then returns 1175.
REQ-037 Random sweep of all a in 1..3328 -> (a*result) mod 3329 == 1, and done pulse width == 1.
